// File: rtl/cp0_mmu_regs.sv
// CP0 register file with TLB management registers, timer and interrupt logic.
// Exceptions, eret, mtc0 and TLB ops commit here beside WB; mfc0 reads are combinational.
module cp0_mmu_regs #(
  parameter int          TLBNUM       = 16,
  parameter int          IDXW         = $clog2(TLBNUM),
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] COMPARE_INIT = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      cp0_addr,
  input  logic            mtc0_we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            wb_ex,
  input  logic [4:0]      wb_excode,
  input  logic            wb_bd,
  input  logic [31:0]     wb_pc,
  input  logic [31:0]     wb_badvaddr,
  input  logic            eret,
  input  logic [5:0]      ext_int,
  input  logic            tlbp,
  input  logic            tlbp_found,
  input  logic [IDXW-1:0] tlbp_index,
  input  logic            tlbr,
  input  logic [26:0]     tlbr_hi,
  input  logic [25:0]     tlbr_lo0,
  input  logic [25:0]     tlbr_lo1,
  output logic [31:0]     entryhi,
  output logic [31:0]     entrylo0,
  output logic [31:0]     entrylo1,
  output logic [IDXW-1:0] index,
  output logic [IDXW-1:0] random,
  output logic [31:0]     epc,
  output logic            int_req
);

  localparam int DIVW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [IDXW-1:0] RND_MAX = IDXW'(TLBNUM - 1);
  localparam logic [DIVW-1:0] DIV_MAX = DIVW'(COUNT_DIV - 1);

  localparam logic [7:0] A_INDEX  = 8'h00;
  localparam logic [7:0] A_RANDOM = 8'h08;
  localparam logic [7:0] A_LO0    = 8'h10;
  localparam logic [7:0] A_LO1    = 8'h18;
  localparam logic [7:0] A_WIRED  = 8'h30;
  localparam logic [7:0] A_BADVA  = 8'h40;
  localparam logic [7:0] A_COUNT  = 8'h48;
  localparam logic [7:0] A_HI     = 8'h50;
  localparam logic [7:0] A_CMP    = 8'h58;
  localparam logic [7:0] A_STATUS = 8'h60;
  localparam logic [7:0] A_CAUSE  = 8'h68;
  localparam logic [7:0] A_EPC    = 8'h70;

  logic [7:0]      im_q, im_d;
  logic            exl_q, exl_d, ie_q, ie_d;
  logic            bd_q, bd_d, ti_q, ti_d;
  logic [5:0]      ip_hw_q, ip_hw_d;
  logic [1:0]      ip_sw_q, ip_sw_d;
  logic [4:0]      exccode_q, exccode_d;
  logic [31:0]     epc_q, epc_d, badva_q, badva_d;
  logic [31:0]     count_q, count_d, cmp_q, cmp_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [18:0]     vpn2_q, vpn2_d;
  logic [7:0]      asid_q, asid_d;
  logic [25:0]     lo0_q, lo0_d, lo1_q, lo1_d;
  logic            idx_p_q, idx_p_d;
  logic [IDXW-1:0] idx_q, idx_d, rnd_q, rnd_d, wired_q, wired_d;

  // exception commit suppresses every other commit in the same cycle
  logic we, eret_v, tlbp_v, tlbr_v, tlb_code, badva_code;
  assign we     = mtc0_we & ~wb_ex;
  assign eret_v = eret & ~wb_ex;
  assign tlbp_v = tlbp & ~wb_ex;
  assign tlbr_v = tlbr & ~wb_ex;
  assign tlb_code = (wb_excode == 5'd1) | (wb_excode == 5'd2)
                  | (wb_excode == 5'd3);
  assign badva_code = tlb_code | (wb_excode == 5'd4)
                    | (wb_excode == 5'd5);

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ti_d      = ti_q;
    ip_hw_d   = {ext_int[5] | ti_q, ext_int[4:0]};
    ip_sw_d   = ip_sw_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    badva_d   = badva_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    div_d     = div_q;
    vpn2_d    = vpn2_q;
    asid_d    = asid_q;
    lo0_d     = lo0_q;
    lo1_d     = lo1_q;
    idx_p_d   = idx_p_q;
    idx_d     = idx_q;
    wired_d   = wired_q;
    rnd_d     = (rnd_q == wired_q) ? RND_MAX : rnd_q - 1'b1;

    if (we && cp0_addr == A_COUNT) begin
      count_d = wdata;
      div_d   = '0;
    end else if (div_q == DIV_MAX) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (count_q == cmp_q) ti_d = 1'b1;
    if (we && cp0_addr == A_CMP) begin
      cmp_d = wdata;
      ti_d  = 1'b0;
    end

    if (we && cp0_addr == A_STATUS) begin
      im_d  = wdata[15:8];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (eret_v) exl_d = 1'b0;
    if (we && cp0_addr == A_CAUSE) ip_sw_d = wdata[9:8];
    if (we && cp0_addr == A_EPC) epc_d = wdata;
    if (we && cp0_addr == A_HI) begin
      vpn2_d = wdata[31:13];
      asid_d = wdata[7:0];
    end
    if (we && cp0_addr == A_LO0) lo0_d = wdata[25:0];
    if (we && cp0_addr == A_LO1) lo1_d = wdata[25:0];
    if (we && cp0_addr == A_INDEX) idx_d = wdata[IDXW-1:0];
    if (we && cp0_addr == A_WIRED && wdata < 32'(TLBNUM)) begin
      wired_d = wdata[IDXW-1:0];
      rnd_d   = RND_MAX;
    end

    if (tlbr_v) begin
      vpn2_d = tlbr_hi[26:8];
      asid_d = tlbr_hi[7:0];
      lo0_d  = tlbr_lo0;
      lo1_d  = tlbr_lo1;
    end
    if (tlbp_v) begin
      idx_p_d = ~tlbp_found;
      idx_d   = tlbp_found ? tlbp_index : '0;
    end

    if (wb_ex) begin
      exl_d     = 1'b1;
      exccode_d = wb_excode;
      if (!exl_q) begin
        bd_d  = wb_bd;
        epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
      end
      if (badva_code) badva_d = wb_badvaddr;
      if (tlb_code) vpn2_d = wb_badvaddr[31:13];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      ip_hw_q   <= '0;
      ip_sw_q   <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
      badva_q   <= '0;
      count_q   <= '0;
      cmp_q     <= COMPARE_INIT;
      div_q     <= '0;
      vpn2_q    <= '0;
      asid_q    <= '0;
      lo0_q     <= '0;
      lo1_q     <= '0;
      idx_p_q   <= 1'b0;
      idx_q     <= '0;
      wired_q   <= '0;
      rnd_q     <= RND_MAX;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      ip_hw_q   <= ip_hw_d;
      ip_sw_q   <= ip_sw_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      badva_q   <= badva_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      div_q     <= div_d;
      vpn2_q    <= vpn2_d;
      asid_q    <= asid_d;
      lo0_q     <= lo0_d;
      lo1_q     <= lo1_d;
      idx_p_q   <= idx_p_d;
      idx_q     <= idx_d;
      wired_q   <= wired_d;
      rnd_q     <= rnd_d;
    end
  end

  assign entryhi  = {vpn2_q, 5'b0, asid_q};
  assign entrylo0 = {6'b0, lo0_q};
  assign entrylo1 = {6'b0, lo1_q};
  assign index    = idx_q;
  assign random   = rnd_q;
  assign epc      = epc_q;
  assign int_req  = ie_q & ~exl_q & |({ip_hw_q, ip_sw_q} & im_q);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      cp0_addr == A_INDEX:  rdata = {idx_p_q, {(31-IDXW){1'b0}}, idx_q};
      cp0_addr == A_RANDOM: rdata = 32'(rnd_q);
      cp0_addr == A_LO0:    rdata = entrylo0;
      cp0_addr == A_LO1:    rdata = entrylo1;
      cp0_addr == A_WIRED:  rdata = 32'(wired_q);
      cp0_addr == A_BADVA:  rdata = badva_q;
      cp0_addr == A_COUNT:  rdata = count_q;
      cp0_addr == A_HI:     rdata = entryhi;
      cp0_addr == A_CMP:    rdata = cmp_q;
      cp0_addr == A_STATUS:
        rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      cp0_addr == A_CAUSE:
        rdata = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q,
                 1'b0, exccode_q, 2'b0};
      cp0_addr == A_EPC:    rdata = epc_q;
      default:              rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_mmu_regs.sv
// Directed bench for cp0_mmu_regs: reset, timer, exceptions,
// Random/Wired, TLB probe/read, async reset.
module tb_cp0_mmu_regs;

  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      cp0_addr;
  logic            mtc0_we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            wb_ex;
  logic [4:0]      wb_excode;
  logic            wb_bd;
  logic [31:0]     wb_pc;
  logic [31:0]     wb_badvaddr;
  logic            eret;
  logic [5:0]      ext_int;
  logic            tlbp;
  logic            tlbp_found;
  logic [IDXW-1:0] tlbp_index;
  logic            tlbr;
  logic [26:0]     tlbr_hi;
  logic [25:0]     tlbr_lo0;
  logic [25:0]     tlbr_lo1;
  logic [31:0]     entryhi;
  logic [31:0]     entrylo0;
  logic [31:0]     entrylo1;
  logic [IDXW-1:0] index;
  logic [IDXW-1:0] random;
  logic [31:0]     epc;
  logic            int_req;

  int nvec = 0;
  int nerr = 0;

  cp0_mmu_regs dut (
    .clk(clk), .reset(reset), .cp0_addr(cp0_addr),
    .mtc0_we(mtc0_we), .wdata(wdata), .rdata(rdata),
    .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret(eret),
    .ext_int(ext_int), .tlbp(tlbp), .tlbp_found(tlbp_found),
    .tlbp_index(tlbp_index), .tlbr(tlbr), .tlbr_hi(tlbr_hi),
    .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1),
    .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1),
    .index(index), .random(random), .epc(epc), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mtc0_we = 1'b0;
    wb_ex   = 1'b0;
    eret    = 1'b0;
    tlbp    = 1'b0;
    tlbr    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    cp0_addr = a;
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cp0_addr = a;
    wdata    = d;
    mtc0_we  = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; cp0_addr = '0; mtc0_we = 0; wdata = '0;
    wb_ex = 0; wb_excode = '0; wb_bd = 0; wb_pc = '0;
    wb_badvaddr = '0; eret = 0; ext_int = '0; tlbp = 0;
    tlbp_found = 0; tlbp_index = '0; tlbr = 0; tlbr_hi = '0;
    tlbr_lo0 = '0; tlbr_lo1 = '0;
    #12;
    rd(8'h60); chk("rst_status", rdata, 32'h0040_0000);
    rd(8'h08); chk("rst_random", rdata, 32'd15);
    rd(8'h58); chk("rst_compare", rdata, 32'hFFFF_FFFF);
    rd(8'h68); chk("rst_cause", rdata, 32'h0);
    chk("rst_int_req", 32'(int_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // timer: Count cleared last so it ticks every 2 edges from 0
    wr(8'h60, 32'h0000_8001);
    wr(8'h58, 32'd10);
    wr(8'h48, 32'd0);
    repeat (20) step();
    rd(8'h48); chk("count_10", rdata, 32'd10);
    rd(8'h68); chk("ti_before", 32'(rdata[30]), 32'd0);
    step();
    rd(8'h68); chk("ti_set", 32'(rdata[30]), 32'd1);
    chk("ip7_lag", 32'(rdata[15]), 32'd0);
    step();
    rd(8'h68); chk("ip7_set", 32'(rdata[15]), 32'd1);
    chk("int_req_timer", 32'(int_req), 32'd1);
    wr(8'h58, 32'd1000);
    rd(8'h68); chk("ti_clear", 32'(rdata[30]), 32'd0);

    // Random / Wired
    wr(8'h30, 32'd4);
    chk("rnd_reload", 32'(random), 32'd15);
    for (int i = 14; i >= 4; i--) begin
      step();
      chk("rnd_down", 32'(random), 32'(i));
    end
    step();
    chk("rnd_wrap", 32'(random), 32'd15);
    wr(8'h30, 32'd20);
    rd(8'h30); chk("wired_ignore", rdata, 32'd4);

    // exceptions
    wb_ex = 1; wb_excode = 5'd3; wb_bd = 1;
    wb_pc = 32'h8000_1004; wb_badvaddr = 32'h0040_2ABC;
    step();
    chk("epc_bd", epc, 32'h8000_1000);
    rd(8'h68); chk("cause_tlbs", rdata, 32'h8000_000C);
    rd(8'h60); chk("status_exl", rdata, 32'h0040_8003);
    rd(8'h40); chk("badva_tlbs", rdata, 32'h0040_2ABC);
    chk("ehi_vpn2", 32'(entryhi[31:13]), 32'h00201);
    chk("int_req_exl", 32'(int_req), 32'd0);
    wb_ex = 1; wb_excode = 5'd4; wb_bd = 0;
    wb_pc = 32'h8000_2000; wb_badvaddr = 32'h0000_1234;
    cp0_addr = 8'h70; wdata = 32'h0000_DEAD; mtc0_we = 1;
    step();
    chk("epc_hold", epc, 32'h8000_1000);
    rd(8'h68); chk("cause_adel", rdata, 32'h8000_0010);
    rd(8'h40); chk("badva_adel", rdata, 32'h0000_1234);
    chk("ehi_vpn2_hold", 32'(entryhi[31:13]), 32'h00201);
    eret = 1;
    step();
    rd(8'h60); chk("status_eret", rdata, 32'h0040_8001);

    // TLB registers
    wr(8'h50, 32'hFFFF_FFFF);
    chk("ehi_mask", entryhi, 32'hFFFF_E0FF);
    tlbp = 1; tlbp_found = 1; tlbp_index = 4'd7;
    step();
    rd(8'h00); chk("tlbp_hit", rdata, 32'h0000_0007);
    tlbp = 1; tlbp_found = 0; tlbp_index = 4'd9;
    step();
    rd(8'h00); chk("tlbp_miss", rdata, 32'h8000_0000);
    tlbr = 1; tlbr_hi = {19'h12345, 8'hAB};
    tlbr_lo0 = 26'h3FF_FFFF; tlbr_lo1 = 26'h1;
    cp0_addr = 8'h10; wdata = 32'h0; mtc0_we = 1;
    step();
    rd(8'h10); chk("tlbr_lo0", rdata, 32'h03FF_FFFF);
    chk("tlbr_lo1", entrylo1, 32'h0000_0001);
    chk("tlbr_hi", entryhi, 32'h2468_A0AB);

    // async reset with EXL set
    wb_ex = 1; wb_excode = 5'd0;
    step();
    rd(8'h60); chk("exl_pre_rst", 32'(rdata[1]), 32'd1);
    repeat (3) step();
    reset = 1'b1;
    rd(8'h48); chk("arst_count", rdata, 32'd0);
    rd(8'h60); chk("arst_status", rdata, 32'h0040_0000);
    chk("arst_random", 32'(random), 32'd15);
    chk("arst_int_req", 32'(int_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
